// File: rtl/module_display_7seg.sv
// Four-digit multiplexed 7-segment driver: captures BCD digits on listo and scans them
// with a per-slot blank window. Optional macro LEADING_ZERO_BLANK_EN suppresses leading zeros.
module module_display_7seg #(
  parameter int REFRESH_DIV  = 27000,
  parameter int BLANK_CYCLES = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] unidades_input,
  input  logic [3:0] decenas_input,
  input  logic [3:0] centenas_input,
  input  logic [3:0] millares_input,
  input  logic       listo,
  output logic [6:0] segmentos,
  output logic [3:0] anodos,
  output logic       actualizado
);

  typedef enum logic [1:0] {SCAN_U, SCAN_D, SCAN_C, SCAN_M} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] BLANK_LIM = 16'(BLANK_CYCLES);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [15:0] digits_q, digits_d;
  logic        act_q, act_d;
  logic [6:0]  seg_q, seg_d;
  logic [3:0]  an_q, an_d;
  logic [3:0]  cur_digit;
  logic        cur_blank;
  logic        blank_m, blank_c, blank_d;

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  // Outputs are computed from next-state values so the registered anodes/segments
  // always line up with the registered prescaler and display register.
  always_comb begin
    digits_d = digits_q;
    act_d    = listo;
    presc_d  = presc_q + 16'd1;
    state_d  = state_q;
    if (listo) begin
      digits_d = {millares_input, centenas_input, decenas_input, unidades_input};
    end
    if (presc_q == PRESC_MAX) begin
      presc_d = 16'd0;
      case (state_q)
        SCAN_U:  state_d = SCAN_D;
        SCAN_D:  state_d = SCAN_C;
        SCAN_C:  state_d = SCAN_M;
        SCAN_M:  state_d = SCAN_U;
        default: state_d = SCAN_U;
      endcase
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  assign blank_m = (digits_d[15:12] == 4'd0);
  assign blank_c = blank_m && (digits_d[11:8] == 4'd0);
  assign blank_d = blank_c && (digits_d[7:4] == 4'd0);
`else
  assign blank_m = 1'b0;
  assign blank_c = 1'b0;
  assign blank_d = 1'b0;
`endif

  always_comb begin
    cur_digit = digits_d[3:0];
    cur_blank = 1'b0;
    an_d      = 4'b1111;
    seg_d     = 7'b1111111;
    case (state_d)
      SCAN_U: begin cur_digit = digits_d[3:0];   cur_blank = 1'b0;    an_d = 4'b1110; end
      SCAN_D: begin cur_digit = digits_d[7:4];   cur_blank = blank_d; an_d = 4'b1101; end
      SCAN_C: begin cur_digit = digits_d[11:8];  cur_blank = blank_c; an_d = 4'b1011; end
      SCAN_M: begin cur_digit = digits_d[15:12]; cur_blank = blank_m; an_d = 4'b0111; end
      default: begin cur_digit = 4'd0; cur_blank = 1'b1; an_d = 4'b1111; end
    endcase
    if (presc_d < BLANK_LIM) begin
      an_d = 4'b1111;
    end else if (!cur_blank) begin
      seg_d = decode(cur_digit);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SCAN_U;
      presc_q  <= 16'd0;
      digits_q <= 16'd0;
      act_q    <= 1'b0;
      seg_q    <= 7'b1111111;
      an_q     <= 4'b1111;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      digits_q <= digits_d;
      act_q    <= act_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
    end
  end

  assign segmentos   = seg_q;
  assign anodos      = an_q;
  assign actualizado = act_q;

endmodule

// File: tb/tb_module_display_7seg.sv
// Scoreboard bench for module_display_7seg (REFRESH_DIV=8, BLANK_CYCLES=2); honours LEADING_ZERO_BLANK_EN.
module tb_module_display_7seg;

  logic       clk;
  logic       rst;
  logic [3:0] unidades_input, decenas_input, centenas_input, millares_input;
  logic       listo;
  logic [6:0] segmentos;
  logic [3:0] anodos;
  logic       actualizado;

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       act;
  } exp_t;

  exp_t        sb_q[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int          m_presc = 0;
  int          m_slot  = 0;
  logic [15:0] m_dig   = 16'h0000;

  module_display_7seg #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .unidades_input (unidades_input),
    .decenas_input  (decenas_input),
    .centenas_input (centenas_input),
    .millares_input (millares_input),
    .listo          (listo),
    .segmentos      (segmentos),
    .anodos         (anodos),
    .actualizado    (actualizado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input logic [3:0] v);
    case (v)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic logic slot_blank(input int slot, input logic [15:0] d);
`ifdef LEADING_ZERO_BLANK_EN
    case (slot)
      3: return d[15:12] == 4'd0;
      2: return d[15:8] == 8'd0;
      1: return d[15:4] == 12'd0;
      default: return 1'b0;
    endcase
`else
    return 1'b0;
`endif
  endfunction

  // Drive one clock's inputs and queue the outputs expected right after that edge.
  task automatic step(input logic r, input logic l, input logic [15:0] d);
    exp_t e;
    @(negedge clk);
    rst = r;
    listo = l;
    {millares_input, centenas_input, decenas_input, unidades_input} = d;
    if (r) begin
      m_presc = 0; m_slot = 0; m_dig = 16'h0000;
      e.act = 1'b0; e.an = 4'b1111; e.seg = 7'b1111111;
    end else begin
      e.act = l;
      if (l) m_dig = d;
      if (m_presc == 7) begin
        m_presc = 0;
        m_slot  = (m_slot + 1) % 4;
      end else begin
        m_presc++;
      end
      if (m_presc < 2) begin
        e.an = 4'b1111; e.seg = 7'b1111111;
      end else begin
        e.an = ~(4'b0001 << m_slot);
        e.seg = slot_blank(m_slot, m_dig) ? 7'b1111111 : seg_of(m_dig[m_slot*4 +: 4]);
      end
    end
    sb_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'hA5A5);
  endtask

  // Monitor: one transaction per clock, compared against the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_chk += 3;
        if (anodos !== e.an) begin
          n_fail++;
          $display("FAIL anodos t=%0t got %b want %b", $time, anodos, e.an);
        end
        if (segmentos !== e.seg) begin
          n_fail++;
          $display("FAIL segmentos t=%0t an=%b got %b want %b", $time, anodos, segmentos, e.seg);
        end
        if (actualizado !== e.act) begin
          n_fail++;
          $display("FAIL actualizado t=%0t got %b want %b", $time, actualizado, e.act);
        end
        $display("txn t=%0t an=%b seg=%b act=%b", $time, anodos, segmentos, actualizado);
      end
    end
  end

  initial begin
    rst = 1'b0; listo = 1'b0;
    unidades_input = 4'd0; decenas_input = 4'd0; centenas_input = 4'd0; millares_input = 4'd0;

    // Reset for 3 cycles, then free run showing the first lit anode at prescaler 2.
    repeat (3) step(1'b1, 1'b0, 16'h0000);
    idle(2);
    // Capture 1,2,3,4 (millares..unidades) and scan 40 cycles.
    step(1'b0, 1'b1, 16'h1234);
    idle(40);
    // Leading-zero pattern 0,0,7,0.
    step(1'b0, 1'b1, 16'h0070);
    idle(34);
    // Invalid BCD in unidades.
    step(1'b0, 1'b1, 16'h569C);
    idle(33);
    // listo held high over several edges with changing digits.
    step(1'b0, 1'b1, 16'h8001);
    step(1'b0, 1'b1, 16'h8002);
    step(1'b0, 1'b1, 16'h0803);
    step(1'b0, 1'b1, 16'h0F04);
    idle(10);
    // Capture coinciding with a prescaler wrap.
    for (int i = 0; i < 8 && m_presc != 7; i++) idle(1);
    step(1'b0, 1'b1, 16'h0905);
    idle(20);
    // Reset in the middle of SCAN_C with listo high on the same edge.
    for (int i = 0; i < 40 && !(m_slot == 2 && m_presc == 4); i++) idle(1);
    step(1'b1, 1'b1, 16'h9999);
    idle(36);

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    n_chk++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/module_display_7seg.md
MODULE_DISPLAY_7SEG -- requirements
Module: module_display_7seg

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 27000, clk cycles per digit slot (legal range 4..65535).
REQ-002 SHALL have parameter BLANK_CYCLES, default 100, cycles at the start of each slot with all anodes off (legal range 1..REFRESH_DIV-2).
REQ-003 SHALL have port clk  input  1  system clock; single clock domain.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have ports unidades_input, decenas_input, centenas_input, millares_input  input  4 each  BCD digits from the upstream divisor.
REQ-006 SHALL have port listo  input  1  digits valid; captured on any clk edge where high.
REQ-007 SHALL have port segmentos  output  7  active-low segments, bit0=a ... bit6=g.
REQ-008 SHALL have port anodos  output  4  active-low digit enables, bit0=unidades ... bit3=millares.
REQ-009 SHALL have port actualizado  output  1  one-cycle pulse, the cycle after a capture.

Function
REQ-010 SHALL hold a 16-bit display register; on an edge with listo=1 it loads all four inputs at once; with listo=0 it holds.
REQ-011 SHALL assert actualizado for exactly one cycle after each capture edge; if listo is high continuously, actualizado SHALL stay high.
REQ-012 SHALL run a prescaler 0..REFRESH_DIV-1 that wraps to 0; the wrap edge SHALL advance the scan FSM.
REQ-013 SHALL implement FSM states SCAN_U -> SCAN_D -> SCAN_C -> SCAN_M -> SCAN_U, one state per slot, with no other transitions.
REQ-014 SHALL drive anodos=4'b1111 while prescaler < BLANK_CYCLES; otherwise it SHALL drive exactly one anode low, the one for the current state.
REQ-015 SHALL register segmentos and anodos; both outputs SHALL update on the same edge.
REQ-016 SHALL decode 0-9 to the standard patterns: 0=7'b1000000, 1=7'b1111001, 7=7'b1111000, 8=7'b0000000.
REQ-017 SHALL decode digit values 10-15 to a dash, 7'b0111111.
REQ-018 SHALL drive segmentos=7'b1111111 during blank cycles and for blanked digits.
REQ-019 SHALL make new digits visible on segmentos at the edge after capture (latency 1), provided the slot is not in its blank window.
REQ-020 SHALL update only the display register on a capture that coincides with a prescaler wrap; the state advance SHALL proceed normally.
REQ-021 SHALL treat the scan as free-running and independent of listo.

Reset
REQ-022 SHALL, on any edge with rst=1, clear the display register, prescaler and actualizado, set the FSM to SCAN_U, and drive anodos=4'b1111 and segmentos=7'b1111111.
REQ-023 SHALL give rst priority over a simultaneous listo, so no capture occurs on that edge.
REQ-024 SHALL, on reset mid-slot, abort the slot immediately; after release, scanning SHALL restart at SCAN_U with prescaler 0.

Configuration
REQ-025 SHALL support the macro LEADING_ZERO_BLANK_EN.
REQ-026 SHALL, when LEADING_ZERO_BLANK_EN is defined, blank:
- millares when it is 0;
- centenas when millares and centenas are 0;
- decenas when millares, centenas and decenas are 0;
- unidades never.
REQ-027 SHALL, when LEADING_ZERO_BLANK_EN is undefined, display all four digits, including leading zeros.

Verification (bench uses REFRESH_DIV=8, BLANK_CYCLES=2)
REQ-028 SHALL verify reset: rst high for 3 cycles -> anodos=1111, segmentos=1111111, actualizado=0; after release, the first anode low is anodos=1110 at prescaler=2.
REQ-029 SHALL verify capture and decode: listo pulse with digits 1,2,3,4 (millares..unidades) -> actualizado pulses once; anodos=1110 shows 4 (7'b0011001), 1101 shows 3, 1011 shows 2, 0111 shows 1 (7'b1111001).
REQ-030 SHALL verify scan timing: 40 cycles of free run -> each anode low for exactly 6 consecutive cycles, then 2 all-off cycles, in order bit0..bit3, then wrap.
REQ-031 SHALL verify blanking: digits 0,0,7,0 -> with LEADING_ZERO_BLANK_EN, millares and centenas slots give 1111111, decenas gives 7'b1111000, unidades gives 7'b1000000; without the macro, all four slots lit.
REQ-032 SHALL verify invalid BCD: unidades_input=4'hC with listo=1 -> the unidades slot shows 7'b0111111.
REQ-033 SHALL verify reset mid-operation: rst asserted during SCAN_C with listo=1 on the same edge -> display register reads 0, no actualizado pulse, and the scan restarts at SCAN_U.
